// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic valid/ready pipeline register with a two-entry skid buffer, flush and occupancy.
module pipe_skid_reg #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t           r_state, w_next;
    logic             r_in_ready, r_out_valid;
    logic [WIDTH-1:0] r_main, r_skid;
    logic             w_in_fire, w_out_fire, w_load_main, w_main_from_skid, w_load_skid;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main;
    // state encoding doubles as the entry count
    assign occupancy  = r_state;

    always_comb begin
        w_next           = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                w_next      = w_in_fire ? ONE : EMPTY;
                w_load_main = w_in_fire;
            end
            ONE: begin
                w_next      = (w_in_fire & ~w_out_fire) ? TWO : (w_out_fire & ~w_in_fire) ? EMPTY : ONE;
                w_load_main = w_in_fire & w_out_fire;
                w_load_skid = w_in_fire & ~w_out_fire;
            end
            TWO: begin
                w_next           = w_out_fire ? ONE : TWO;
                w_load_main      = w_out_fire;
                w_main_from_skid = w_out_fire;
            end
            default: w_next = EMPTY;
        endcase
        // flush drops everything held; data registers are left untouched
        if (flush) begin
            w_next           = EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= RESET_VALUE;
            r_skid      <= RESET_VALUE;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next != TWO);
            r_out_valid <= (w_next != EMPTY);
            if (w_load_main) r_main <= w_main_from_skid ? r_skid : in_data;
            if (w_load_skid) r_skid <= in_data;
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: randomized and directed scoreboard bench for pipe_skid_reg.
module tb_pipe_skid_reg;
    localparam int unsigned      WIDTH = 32;
    localparam logic [WIDTH-1:0] RV    = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [1:0]       occupancy;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_out;
    bit               armed = 1'b0;
    int               n_vec = 0, n_err = 0;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the register behaves as a FIFO of depth two whose head is shown on out_data.
    always @(negedge clk) begin
        if (armed) begin
            chk("occupancy", 32'(occupancy), 32'(sb.size()));
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
            chk("out_data", out_data, exp_out);
            if (out_valid && out_ready && !reset) begin
                if (sb.size() == 0) chk("emit_when_empty", 32'(out_valid), 32'd0);
                else chk("pop_order", out_data, sb.pop_front());
            end
            if (!reset && !flush && in_valid && in_ready) sb.push_back(in_data);
        end
        if (reset) begin
            sb.delete();
            exp_out = RV;
            armed   = 1'b1;
        end else if (flush) sb.delete();
        if (sb.size() != 0) exp_out = sb[0];
    end

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [WIDTH-1:0] id, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held two cycles while upstream offers data
        drive(1, 0, 1, 32'hFF, 0);
        drive(1, 0, 1, 32'hFF, 0);
        // streaming
        drive(0, 0, 1, 32'hA5, 1);
        drive(0, 0, 1, 32'h3C, 1);
        drive(0, 0, 1, 32'h5A, 1);
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        // backpressure into the skid entry
        drive(0, 0, 1, 32'h11, 0);
        drive(0, 0, 1, 32'h22, 0);
        drive(0, 0, 1, 32'h33, 0);
        drive(0, 0, 1, 32'h33, 0);
        drive(0, 0, 1, 32'h33, 1);
        drive(0, 0, 1, 32'h33, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 1);
        // flush while full, with a concurrent offer
        drive(0, 0, 1, 32'h11, 0);
        drive(0, 0, 1, 32'h22, 0);
        drive(0, 1, 1, 32'h99, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 1);
        // reset while full, then a fresh item
        drive(0, 0, 1, 32'h44, 0);
        drive(0, 0, 1, 32'h55, 0);
        drive(1, 0, 1, 32'h66, 1);
        drive(0, 0, 1, 32'h77, 0);
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        // random traffic with varying pressure, occasional flush and reset
        for (int b = 0; b < 10; b++) begin
            int pv, pr;
            pv = 30 + int'($urandom_range(65));
            pr = 10 + int'($urandom_range(85));
            for (int i = 0; i < 1000; i++)
                drive($urandom_range(499) == 0, $urandom_range(79) == 0,
                      $urandom_range(99) < pv, $urandom, $urandom_range(99) < pr);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, $urandom, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
